bneck_mem_stream_reader: RTL and testbench

//  Read-side initiator for one bottleneck feature-map memory segment. It is the

---
 rtl/bneck_pkg.sv | 25 ++
 rtl/bneck_skid_fifo.sv | 61 ++++++
 rtl/bneck_mem_stream_reader.sv | 147 ++++++++++++++
 tb/tb_bneck_mem_stream_reader.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bneck_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bneck_pkg : shared sizes, FSM state type and address-wrap helper
// Revision  : 1.0
// ----------------------------------------------------------------------------
package bneck_pkg;

  localparam int BITSIZE = 14;
  localparam int ADDR_W  = 14;
  localparam int HEIGHT  = 12544;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Segment index successor; the segment is not a power of two deep.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] idx);
    return (idx == ADDR_W'(HEIGHT - 1)) ? '0 : idx + ADDR_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bneck_skid_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bneck_skid_fifo : 2-entry pixel buffer with synchronous flush
// Revision        : 1.0
// ----------------------------------------------------------------------------
module bneck_skid_fifo
  import bneck_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic [BITSIZE-1:0] wdata,
  input  logic               pop,
  output logic [BITSIZE-1:0] rdata,
  output logic               full,
  output logic               empty,
  output logic [1:0]         count
);

  logic [BITSIZE-1:0] slot_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         count_q;
  logic               push_ok;
  logic               pop_ok;

  always_comb begin
    full    = (count_q == 2'd2);
    empty   = (count_q == 2'd0);
    count   = count_q;
    rdata   = slot_q[rd_ptr_q];
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        slot_q[wr_ptr_q] <= wdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule
`default_nettype wire

// File: rtl/bneck_mem_stream_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bneck_mem_stream_reader : reads COUNT pixels from a segment into a stream
// Revision                : 1.0
// ----------------------------------------------------------------------------
module bneck_mem_stream_reader
  import bneck_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_W-1:0]         base,
  input  logic [ADDR_W-1:0]         count,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_en,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_index,
  input  logic [BITSIZE-1:0]        mem_rdata,
  output logic signed [BITSIZE-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  count_q;
  logic [ADDR_W-1:0]  issued_q;
  logic [ADDR_W-1:0]  beat_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               inflight_q;

  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [BITSIZE-1:0] fifo_rdata;

  logic               start_ok;
  logic               flush;
  logic               accept;
  logic               reads_left;
  logic [2:0]         occupancy;
  logic               issue;
  logic               last_issue;

  // Occupancy counts the slot freed by this cycle's pop so a steady stream
  // keeps one read in flight every cycle with only two entries of storage.
  always_comb begin
    start_ok   = (state_q == IDLE) && start && !abort;
    flush      = abort && ((state_q == RUN) || (state_q == DRAIN));
    out_valid  = !fifo_empty;
    accept     = out_valid && out_ready;
    out_last   = out_valid && (beat_q == count_q - ADDR_W'(1));
    reads_left = (issued_q != count_q);
    occupancy  = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, accept};
    issue      = (state_q == RUN) && !abort && reads_left && !fifo_full
                 && (occupancy < 3'd2);
    last_issue = issue && (issued_q == count_q - ADDR_W'(1));
  end

  assign mem_en    = issue;
  assign mem_rd    = issue;
  assign mem_wr    = 1'b0;
  assign mem_index = issue ? addr_q : idx_q;
  assign out_data  = fifo_empty ? '0 : $signed(fifo_rdata);

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      issued_q   <= '0;
      beat_q     <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (start_ok) begin
        count_q  <= count;
        addr_q   <= base;
        issued_q <= '0;
        beat_q   <= '0;
      end
      if (issue) begin
        addr_q   <= wrap_inc(addr_q);
        idx_q    <= addr_q;
        issued_q <= issued_q + ADDR_W'(1);
      end
      if (accept) begin
        beat_q <= beat_q + ADDR_W'(1);
      end
    end
  end

  // A read returning after an abort lands in the flushed FIFO and is dropped.
  bneck_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (inflight_q),
    .wdata (mem_rdata),
    .pop   (accept),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_bneck_mem_stream_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bneck_mem_stream_reader : directed bench for the segment stream reader
// Revision                   : 1.0
// ----------------------------------------------------------------------------
module tb_bneck_mem_stream_reader;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [13:0]       base;
  logic [13:0]       count;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic              mem_rd;
  logic              mem_wr;
  logic [13:0]       mem_index;
  logic [13:0]       mem_rdata;
  logic signed [13:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  int tests;
  int fails;

  int          cyc;
  int          idx_log[$];
  int          idx_cyc[$];
  logic [13:0] beat_log[$];
  logic        beat_last[$];
  int          beat_cyc[$];
  int          done_log[$];
  int          outstanding;
  int          max_out;
  int          stab_err;
  int          rd_err;
  logic        prev_stall;
  logic [13:0] prev_data;

  bneck_mem_stream_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_index (mem_index),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] pix(input int i);
    return 14'((i * 37 + 5) ^ 32'h1555);
  endfunction

  // Segment model: registered read, data valid one cycle after the read edge.
  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) mem_rdata <= pix(int'(mem_index));
    end
  end

  initial begin
    cyc = 0; outstanding = 0; max_out = 0; stab_err = 0; rd_err = 0;
    prev_stall = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (mem_rd !== mem_en || mem_wr !== 1'b0) rd_err++;
      if (mem_en === 1'b1) begin
        idx_log.push_back(int'(mem_index));
        idx_cyc.push_back(cyc);
        outstanding++;
      end
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        beat_log.push_back(out_data);
        beat_last.push_back(out_last);
        beat_cyc.push_back(cyc);
        outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (done === 1'b1) done_log.push_back(cyc);
      prev_stall = (rst === 1'b1) && (out_valid === 1'b1) && (out_ready !== 1'b1);
      prev_data  = out_data;
      if (busy !== 1'b1) outstanding = 0;
      cyc++;
    end
  end

  function automatic int idx_at(input int n);
    if (n >= 0 && n < idx_log.size()) return idx_log[n];
    return -1;
  endfunction

  function automatic int idx_cyc_at(input int n);
    if (n >= 0 && n < idx_cyc.size()) return idx_cyc[n];
    return -1;
  endfunction

  function automatic logic [13:0] beat_at(input int n);
    if (n >= 0 && n < beat_log.size()) return beat_log[n];
    return 14'h3fff;
  endfunction

  function automatic logic last_at(input int n);
    if (n >= 0 && n < beat_last.size()) return beat_last[n];
    return 1'bx;
  endfunction

  function automatic int beat_cyc_at(input int n);
    if (n >= 0 && n < beat_cyc.size()) return beat_cyc[n];
    return -1;
  endfunction

  task automatic do_start(input int b, input int c, output int s);
    @(posedge clk); #1;
    base = 14'(b); count = 14'(c); start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    #1;
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; base = '0; count = '0; out_ready = 1'b1;
    #2;
    tests++;
    if ({busy, done, mem_en, mem_rd, mem_wr, out_valid, out_last} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {busy, done, mem_en, mem_rd, mem_wr, out_valid, out_last});
    end
    tests++;
    if (out_data !== 14'sd0 || mem_index !== 14'd0) begin
      fails++;
      $display("FAIL reset_data: out_data=%0h mem_index=%0h required 0", out_data, mem_index);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, mem_en, out_valid} !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle: got %b required 0000", {busy, done, mem_en, out_valid});
    end
  endtask

  task automatic test_basic();
    int s, i0, b0, d0;
    bit ok;
    i0 = idx_log.size(); b0 = beat_log.size(); d0 = done_log.size();
    do_start(0, 4, s);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b required 1", busy); end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_timeout: busy=%b required 0", busy); end
    tests++;
    if (idx_log.size() - i0 != 4 || beat_log.size() - b0 != 4) begin
      fails++;
      $display("FAIL basic_counts: reads=%0d beats=%0d required 4/4",
               idx_log.size() - i0, beat_log.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (idx_at(i0 + i) != i || idx_cyc_at(i0 + i) != s + 1 + i) begin
        fails++;
        $display("FAIL basic_read%0d: index=%0d cyc=%0d required %0d/%0d",
                 i, idx_at(i0 + i), idx_cyc_at(i0 + i), i, s + 1 + i);
      end
      tests++;
      if (beat_at(b0 + i) !== pix(i) || beat_cyc_at(b0 + i) != s + 3 + i
          || last_at(b0 + i) !== (i == 3)) begin
        fails++;
        $display("FAIL basic_beat%0d: data=%0h cyc=%0d last=%b required %0h/%0d/%b",
                 i, beat_at(b0 + i), beat_cyc_at(b0 + i), last_at(b0 + i),
                 pix(i), s + 3 + i, (i == 3));
      end
    end
    tests++;
    if (done_log.size() - d0 != 1 || done_log[done_log.size() - 1] != s + 7) begin
      fails++;
      $display("FAIL basic_done: pulses=%0d required 1 at cyc %0d", done_log.size() - d0, s + 7);
    end
  endtask

  task automatic test_wrap();
    int s, i0, b0;
    bit ok;
    int exp_idx[4];
    exp_idx = '{12542, 12543, 0, 1};
    i0 = idx_log.size(); b0 = beat_log.size();
    do_start(12542, 4, s);
    wait_idle(ok);
    tests++;
    if (!ok || idx_log.size() - i0 != 4 || beat_log.size() - b0 != 4) begin
      fails++;
      $display("FAIL wrap_counts: reads=%0d beats=%0d required 4/4",
               idx_log.size() - i0, beat_log.size() - b0);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (idx_at(i0 + i) != exp_idx[i] || beat_at(b0 + i) !== pix(exp_idx[i])
          || last_at(b0 + i) !== (i == 3)) begin
        fails++;
        $display("FAIL wrap_%0d: index=%0d data=%0h last=%b required %0d/%0h/%b",
                 i, idx_at(i0 + i), beat_at(b0 + i), last_at(b0 + i),
                 exp_idx[i], pix(exp_idx[i]), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    int s, i0, b0, d0, e0, k;
    i0 = idx_log.size(); b0 = beat_log.size(); d0 = done_log.size(); e0 = stab_err;
    do_start(20, 5, s);
    k = 0;
    while (busy === 1'b1 && k < 300) begin
      out_ready = (k % 3 == 0);
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL bp_timeout: busy=%b required 0", busy); end
    tests++;
    if (idx_log.size() - i0 != 5 || beat_log.size() - b0 != 5) begin
      fails++;
      $display("FAIL bp_counts: reads=%0d beats=%0d required 5/5",
               idx_log.size() - i0, beat_log.size() - b0);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (beat_at(b0 + i) !== pix(20 + i) || last_at(b0 + i) !== (i == 4)) begin
        fails++;
        $display("FAIL bp_beat%0d: data=%0h last=%b required %0h/%b",
                 i, beat_at(b0 + i), last_at(b0 + i), pix(20 + i), (i == 4));
      end
    end
    tests++;
    if (max_out > 2 || stab_err != e0) begin
      fails++;
      $display("FAIL bp_buffering: max_outstanding=%0d unstable=%0d required <=2/0",
               max_out, stab_err - e0);
    end
    tests++;
    if (done_log.size() - d0 != 1) begin
      fails++;
      $display("FAIL bp_done: pulses=%0d required 1", done_log.size() - d0);
    end
  endtask

  task automatic test_zero_count();
    int s, i0, b0, d0;
    bit ok;
    i0 = idx_log.size(); b0 = beat_log.size(); d0 = done_log.size();
    do_start(7, 0, s);
    wait_idle(ok);
    tests++;
    if (!ok || idx_log.size() != i0 || beat_log.size() != b0) begin
      fails++;
      $display("FAIL zero_activity: reads=%0d beats=%0d required 0/0",
               idx_log.size() - i0, beat_log.size() - b0);
    end
    tests++;
    if (done_log.size() - d0 != 1 || done_log[done_log.size() - 1] != s + 1) begin
      fails++;
      $display("FAIL zero_done: pulses=%0d required 1 at cyc %0d", done_log.size() - d0, s + 1);
    end
  endtask

  task automatic test_abort();
    int s, i0, b0, d0;
    bit ok;
    i0 = idx_log.size(); b0 = beat_log.size(); d0 = done_log.size();
    do_start(40, 8, s);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: busy=%b out_valid=%b required 0/0", busy, out_valid);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (beat_log.size() - b0 != 3 || idx_log.size() - i0 != 4 || done_log.size() != d0) begin
      fails++;
      $display("FAIL abort_counts: beats=%0d reads=%0d dones=%0d required 3/4/0",
               beat_log.size() - b0, idx_log.size() - i0, done_log.size() - d0);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (beat_at(b0 + i) !== pix(40 + i) || last_at(b0 + i) !== 1'b0) begin
        fails++;
        $display("FAIL abort_beat%0d: data=%0h last=%b required %0h/0",
                 i, beat_at(b0 + i), last_at(b0 + i), pix(40 + i));
      end
    end
    b0 = beat_log.size(); d0 = done_log.size();
    do_start(100, 2, s);
    wait_idle(ok);
    tests++;
    if (!ok || beat_log.size() - b0 != 2 || done_log.size() - d0 != 1) begin
      fails++;
      $display("FAIL abort_restart_counts: beats=%0d dones=%0d required 2/1",
               beat_log.size() - b0, done_log.size() - d0);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (beat_at(b0 + i) !== pix(100 + i) || last_at(b0 + i) !== (i == 1)) begin
        fails++;
        $display("FAIL abort_restart_beat%0d: data=%0h last=%b required %0h/%b",
                 i, beat_at(b0 + i), last_at(b0 + i), pix(100 + i), (i == 1));
      end
    end
  endtask

  task automatic test_start_abort_idle();
    int i0;
    i0 = idx_log.size();
    @(posedge clk); #1;
    base = 14'd5; count = 14'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL start_abort_busy: got %b required 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (idx_log.size() != i0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL start_abort_reads: reads=%0d busy=%b required 0/0", idx_log.size() - i0, busy);
    end
  endtask

  task automatic test_reset_midrun();
    int s, i0, d0;
    d0 = done_log.size();
    do_start(200, 6, s);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({busy, done, mem_en, mem_rd, mem_wr, out_valid, out_last} !== 7'b0) begin
      fails++;
      $display("FAIL midrst_ctrl: got %b required 0000000",
               {busy, done, mem_en, mem_rd, mem_wr, out_valid, out_last});
    end
    tests++;
    if (out_data !== 14'sd0 || mem_index !== 14'd0) begin
      fails++;
      $display("FAIL midrst_data: out_data=%0h mem_index=%0h required 0", out_data, mem_index);
    end
    i0 = idx_log.size();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || idx_log.size() != i0 || done_log.size() != d0) begin
      fails++;
      $display("FAIL midrst_after: busy=%b reads=%0d dones=%0d required 0/0/0",
               busy, idx_log.size() - i0, done_log.size() - d0);
    end
  endtask

  task automatic test_start_while_busy();
    int s, i0, b0, d0;
    bit ok;
    i0 = idx_log.size(); b0 = beat_log.size(); d0 = done_log.size();
    do_start(300, 3, s);
    @(posedge clk); #1;
    base = 14'd500; count = 14'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(ok);
    tests++;
    if (!ok || idx_log.size() - i0 != 3 || beat_log.size() - b0 != 3
        || done_log.size() - d0 != 1) begin
      fails++;
      $display("FAIL busy_start_counts: reads=%0d beats=%0d dones=%0d required 3/3/1",
               idx_log.size() - i0, beat_log.size() - b0, done_log.size() - d0);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (idx_at(i0 + i) != 300 + i || beat_at(b0 + i) !== pix(300 + i)
          || last_at(b0 + i) !== (i == 2)) begin
        fails++;
        $display("FAIL busy_start_%0d: index=%0d data=%0h last=%b required %0d/%0h/%b",
                 i, idx_at(i0 + i), beat_at(b0 + i), last_at(b0 + i),
                 300 + i, pix(300 + i), (i == 2));
      end
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (rd_err != 0 || max_out > 2 || stab_err != 0) begin
      fails++;
      $display("FAIL protocol: rd_mismatch=%0d max_outstanding=%0d unstable=%0d required 0/<=2/0",
               rd_err, max_out, stab_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_start_abort_idle();
    test_reset_midrun();
    test_start_while_busy();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
